// File: rtl/wave_pkg.sv
// Shared definitions for the wave path: the slicer state encoding,
// the sample width and the default amplitudes and thresholds that the
// pulse enhancer and the wave slicer agree on.
package wave_pkg;

   typedef enum logic [1:0] {
      WAVE_IDLE    = 2'd0,
      WAVE_QUAL    = 2'd1,
      WAVE_ACTIVE  = 2'd2,
      WAVE_LOCKOUT = 2'd3
   } wave_state_e;

   localparam int WAVE_W         = 15;
   localparam int WAVE_AMP       = 6000;
   localparam int WAVE_PULSE_LEN = 200;
   localparam int WAVE_TH_HI     = 3000;
   localparam int WAVE_TH_LO     = 1500;

endpackage

// File: rtl/wave_slicer_if.sv
// Sample stream in, sliced signal and pulse reports out. The slave side
// is the slicer itself; the master side is the sample source together
// with the sorting control that consumes the reports.
interface wave_slicer_if #(
   parameter int W     = 15,
   parameter int CNT_W = 14
);
   logic                 sample_valid;
   logic signed [W-1:0]  sample;
   logic                 sigout;
   logic                 pulse_rise;
   logic                 pulse_done;
   logic                 pulse_err;
   logic [CNT_W-1:0]     pulse_width;

   modport master (
      output sample_valid, sample,
      input  sigout, pulse_rise, pulse_done, pulse_err, pulse_width
   );

   modport slave (
      input  sample_valid, sample,
      output sigout, pulse_rise, pulse_done, pulse_err, pulse_width
   );
endinterface

// File: rtl/wave_slicer.sv
// Slices the signed sample stream into a clean object-present signal
// using hysteresis thresholds, a minimum-width glitch filter and a
// maximum-width timeout, and reports the width of every finished pulse.
module wave_slicer
   import wave_pkg::*;
#(
   parameter int W     = WAVE_W,
   parameter int CNT_W = 14,
   parameter int TH_HI = WAVE_TH_HI,
   parameter int TH_LO = WAVE_TH_LO,
   parameter int MIN_W = 16,
   parameter int MAX_W = 400
) (
   input  logic          clk,
   input  logic          rst_n,
   wave_slicer_if.slave  bus
);

   localparam logic [1:0] ST_IDLE    = WAVE_IDLE;
   localparam logic [1:0] ST_QUAL    = WAVE_QUAL;
   localparam logic [1:0] ST_ACTIVE  = WAVE_ACTIVE;
   localparam logic [1:0] ST_LOCKOUT = WAVE_LOCKOUT;

   localparam logic signed [W-1:0] TH_HI_S = W'(TH_HI);
   localparam logic signed [W-1:0] TH_LO_S = W'(TH_LO);
   localparam logic [CNT_W-1:0]    MIN_C   = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0]    MAX_C   = CNT_W'(MAX_W);
   localparam logic [CNT_W-1:0]    ONE_C   = CNT_W'(1);

   logic signed [W-1:0] s_q;
   logic                v_q;
   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic                above_hi;
   logic                below_lo;

   assign cnt_inc  = cnt + ONE_C;
   assign above_hi = (s_q >= TH_HI_S);
   assign below_lo = (s_q < TH_LO_S);

   // Input register: holds the accepted sample and marks the cycle in
   // which the FSM is allowed to look at it, so gaps freeze everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
         v_q <= 1'b0;
      end else begin
         v_q <= bus.sample_valid;
         if (bus.sample_valid) begin
            s_q <= bus.sample;
         end
      end
   end

   // Pulse FSM: qualify, track and time out pulses; strobes are cleared
   // every cycle so they last exactly one clock whatever the input does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         bus.sigout      <= 1'b0;
         bus.pulse_rise  <= 1'b0;
         bus.pulse_done  <= 1'b0;
         bus.pulse_err   <= 1'b0;
         bus.pulse_width <= '0;
      end else begin
         bus.pulse_rise <= 1'b0;
         bus.pulse_done <= 1'b0;
         bus.pulse_err  <= 1'b0;
         if (v_q) begin
            case (state)
               ST_IDLE: begin
                  if (above_hi) begin
                     state <= ST_QUAL;
                     cnt   <= ONE_C;
                  end
               end
               ST_QUAL: begin
                  if (below_lo) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc == MIN_C) begin
                        state          <= ST_ACTIVE;
                        bus.sigout     <= 1'b1;
                        bus.pulse_rise <= 1'b1;
                     end
                  end
               end
               ST_ACTIVE: begin
                  if (below_lo) begin
                     state           <= ST_IDLE;
                     cnt             <= '0;
                     bus.sigout      <= 1'b0;
                     bus.pulse_done  <= 1'b1;
                     bus.pulse_width <= cnt;
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc == MAX_C) begin
                        state           <= ST_LOCKOUT;
                        bus.sigout      <= 1'b0;
                        bus.pulse_err   <= 1'b1;
                        bus.pulse_width <= MAX_C;
                     end
                  end
               end
               ST_LOCKOUT: begin
                  if (below_lo) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_slicer.sv
// Scoreboard bench for wave_slicer: the driver feeds directed and random
// sample runs through a run-length reference model that queues expected
// pulse events; a monitor pops and checks them as the strobes appear.
module tb_wave_slicer;

   localparam int W     = 15;
   localparam int CNT_W = 14;
   localparam int TH_HI = 3000;
   localparam int TH_LO = 1500;
   localparam int MIN_W = 16;
   localparam int MAX_W = 400;

   localparam int EV_RISE = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int     kind;
      int     width;
      longint due;
   } event_t;

   logic   clk;
   logic   rst_n;
   longint cyc;
   int     tests;
   int     fails;
   event_t exp_q[$];
   int     run_len;
   bit     exp_sig;
   int     last_width;

   wave_slicer_if #(.W(W), .CNT_W(CNT_W)) bus();

   wave_slicer #(
      .W(W), .CNT_W(CNT_W), .TH_HI(TH_HI), .TH_LO(TH_LO),
      .MIN_W(MIN_W), .MAX_W(MAX_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running clock and a cycle counter used to time expected events.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      tests = tests + 1;
      if (actual !== expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: tracks the length of the current qualifying run
   // and emits events when the run crosses MIN_W, hits MAX_W or ends.
   task automatic modelStep(input int x);
      event_t e;
      e.due   = cyc + 2;
      e.width = 0;
      if (run_len == 0) begin
         if (x >= TH_HI) run_len = 1;
      end else if (x < TH_LO) begin
         if (run_len >= MIN_W && run_len < MAX_W) begin
            e.kind = EV_DONE; e.width = run_len; exp_q.push_back(e);
         end
         run_len = 0;
      end else if (run_len < MAX_W) begin
         run_len = run_len + 1;
         if (run_len == MIN_W) begin
            e.kind = EV_RISE; exp_q.push_back(e);
         end else if (run_len == MAX_W) begin
            e.kind = EV_ERR; e.width = MAX_W; exp_q.push_back(e);
         end
      end
   endtask

   task automatic applyStimulus(input int val, input bit vld);
      @(posedge clk);
      #1;
      bus.sample       = W'(val);
      bus.sample_valid = vld;
      if (vld) modelStep(val);
   endtask

   task automatic sendRun(input int val, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         applyStimulus(val, 1'b1);
         if (gapped) applyStimulus(-7000, 1'b0);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, " sigout"}, bus.sigout, 0);
      checkOutput({tag, " pulse_rise"}, bus.pulse_rise, 0);
      checkOutput({tag, " pulse_done"}, bus.pulse_done, 0);
      checkOutput({tag, " pulse_err"}, bus.pulse_err, 0);
      checkOutput({tag, " pulse_width"}, bus.pulse_width, 0);
   endtask

   // Monitor: every falling edge, match any strobe against the queue head
   // and check sigout/pulse_width against what the popped events imply.
   initial begin
      event_t e;
      int     n;
      int     kind;
      exp_sig    = 1'b0;
      last_width = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_sig    = 1'b0;
            last_width = 0;
         end else begin
            n = int'(bus.pulse_rise) + int'(bus.pulse_done) + int'(bus.pulse_err);
            if (n > 1) checkOutput("strobe count", n, 1);
            if (n >= 1) begin
               kind = bus.pulse_rise ? EV_RISE : (bus.pulse_done ? EV_DONE : EV_ERR);
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected strobe kind", kind, -1);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("event kind", kind, e.kind);
                  checkOutput("event time", cyc, e.due);
                  if (e.kind != EV_RISE) last_width = e.width;
                  exp_sig = (e.kind == EV_RISE);
               end
            end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
               e = exp_q.pop_front();
               checkOutput("missing strobe kind", -1, e.kind);
            end
            checkOutput("sigout", bus.sigout, exp_sig);
            checkOutput("pulse_width", bus.pulse_width, last_width);
         end
      end
   end

   // Driver: reset, directed scenarios, random runs, then drain and report.
   initial begin
      int amps[10];
      int len;
      int amp;
      tests = 0; fails = 0; run_len = 0;
      amps = '{6000, 3500, 3000, 2999, 2000, 1500, 1499, 1000, -100, 0};
      rst_n = 1'b0;
      bus.sample = '0;
      bus.sample_valid = 1'b0;
      #23;
      checkQuiet("reset");
      #4;
      rst_n = 1'b1;

      // Back-to-back 200 sample pulse
      sendRun(6000, 200, 1'b0); sendRun(0, 3, 1'b0);
      // Glitch shorter than MIN_W, and exactly MIN_W-1
      sendRun(6000, 10, 1'b0); sendRun(0, 3, 1'b0);
      sendRun(6000, MIN_W - 1, 1'b0); sendRun(0, 2, 1'b0);
      // Exactly MIN_W samples gives a minimum-width pulse
      sendRun(6000, MIN_W, 1'b0); sendRun(0, 2, 1'b0);
      // Hysteresis pulse of 70, then a mid-band run alone
      sendRun(3500, 20, 1'b0); sendRun(2000, 50, 1'b0); sendRun(1000, 2, 1'b0);
      sendRun(2000, 50, 1'b0); sendRun(0, 2, 1'b0);
      // Timeout, lockout, then a normal pulse
      sendRun(6000, 500, 1'b0); sendRun(3000, 5, 1'b0); sendRun(1000, 1, 1'b0);
      sendRun(6000, 30, 1'b0); sendRun(0, 2, 1'b0);
      // Gapped valid, ended by a negative sample
      sendRun(6000, 30, 1'b1); sendRun(-100, 1, 1'b0); sendRun(0, 2, 1'b0);

      // Reset while ACTIVE
      sendRun(6000, 30, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      bus.sample_valid = 1'b0;
      exp_q.delete();
      run_len = 0;
      #1;
      checkQuiet("async reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sendRun(6000, 40, 1'b0); sendRun(0, 2, 1'b0);

      // Random runs with random amplitudes, lengths and gaps
      for (int r = 0; r < 40; r++) begin
         amp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8000)) - 1000
                                           : amps[$urandom_range(0, 9)];
         len = $urandom_range(1, 450);
         for (int i = 0; i < len; i++) begin
            applyStimulus(amp, ($urandom_range(0, 3) != 0));
         end
      end
      sendRun(0, 2, 1'b0);

      // Drain with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      checkOutput("pending events", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wave_slicer.md
# wave_slicer

Receive-side counterpart of the pulse enhancer: takes the signed 15-bit sample stream that the enhancer (or the ADC path) produces and slices it back into a clean 1-bit object-present signal. It uses hysteresis thresholds, a minimum-width glitch filter and a maximum-width timeout. For every accepted pulse it reports the width in samples. It sits between the sample source and the sorting control logic.

## Interface
- `W`, 15: sample width, signed two's complement.
- `CNT_W`, 14: width of the pulse-width counter.
- `TH_HI`, 3000: signed rising threshold; a pulse starts at sample >= `TH_HI`.
- `TH_LO`, 1500: signed falling threshold; a pulse ends at sample < `TH_LO`. `TH_LO` <= `TH_HI` is required.
- `MIN_W`, 16: minimum qualifying samples before the output asserts; legal range 2..`MAX_W`-1.
- `MAX_W`, 400: width at which the pulse is declared stuck; must be < 2^`CNT_W`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  qualifies `sample`; samples are counted only when it is high.
- `sample`  in  `W`  signed input sample.
- `sigout`  out  1  sliced signal.
- `pulse_rise`  out  1  one-cycle strobe, coincident with `sigout` rising.
- `pulse_done`  out  1  one-cycle strobe on a normal pulse end.
- `pulse_err`  out  1  one-cycle strobe on timeout.
- `pulse_width`  out  `CNT_W`  width of the last finished pulse in accepted samples; holds its value until the next finish.

## Operation
- Input stage: when `sample_valid` is high, `sample` is registered into `s_q` and `v_q` is set to 1; otherwise `v_q` is 0. The FSM acts only on cycles where `v_q` is 1.
- All comparisons are signed. Negative samples are always below `TH_LO`.
- `cnt` counts qualifying samples in the current pulse, including the start sample.
- FSM states: IDLE, QUAL, ACTIVE, LOCKOUT.
- IDLE:
  - `s_q` >= `TH_HI` -> QUAL, `cnt` = 1.
  - Otherwise stay, including for samples between `TH_LO` and `TH_HI`.
- QUAL:
  - `s_q` < `TH_LO` -> IDLE. Glitch is rejected: no strobe, `pulse_width` unchanged.
  - Otherwise `cnt` = `cnt` + 1.
  - If the new `cnt` == `MIN_W` -> ACTIVE; `sigout` = 1 and `pulse_rise` = 1 on the same edge.
- ACTIVE:
  - `s_q` < `TH_LO` -> IDLE; `sigout` = 0, `pulse_done` = 1, `pulse_width` = `cnt`.
  - Otherwise `cnt` = `cnt` + 1.
  - If the new `cnt` == `MAX_W` -> LOCKOUT; `sigout` = 0, `pulse_err` = 1, `pulse_width` = `MAX_W`.
- LOCKOUT: stay until `s_q` < `TH_LO`, then -> IDLE. No strobes. A new pulse can only start from IDLE.
- `cnt` never exceeds `MAX_W`, so no wrap-around is possible.
- At most one strobe is high in any cycle; `pulse_done` and `pulse_err` are mutually exclusive.
- Reset, whether idle or mid-pulse: state = IDLE, `cnt` = 0, `s_q` = 0, `v_q` = 0, `sigout` = 0, all strobes = 0, `pulse_width` = 0.
- The same sample values are not re-evaluated while `sample_valid` is low; gaps freeze the FSM and `cnt`.

## Timing
- All outputs are registered. Two-stage latency: sample accepted at edge k, FSM decision at edge k+1, output visible after edge k+1.
- Rise: the `MIN_W`-th qualifying sample accepted at edge k gives `sigout` = 1 and `pulse_rise` = 1 after edge k+1.
- Fall: the first sample < `TH_LO` accepted at edge k gives `sigout` = 0, `pulse_done` = 1 and `pulse_width` updated after edge k+1.
- Strobes last exactly one clock, independent of `sample_valid`.
- `sample_valid` may toggle every cycle; throughput is one sample per clock.

## Structure
- Shared package `wave_pkg` holds:
  - the state enum (IDLE, QUAL, ACTIVE, LOCKOUT);
  - `WAVE_W` = 15;
  - default amplitudes `WAVE_AMP` = 6000 and `WAVE_PULSE_LEN` = 200, shared with the enhancer;
  - default `TH_HI` and `TH_LO`.
- Single module; no sub-module is warranted. The input register, FSM and counter are one block.

## Test plan
- Back-to-back: 200 valid samples of 6000 followed by 0 -> `sigout` high from the 16th sample (+1 clk) to the first 0 sample (+1 clk); `pulse_rise` once, `pulse_done` once, `pulse_width` = 200.
- Glitch rejection: 10 samples of 6000, then 0 -> `sigout` stays 0, no strobes, `pulse_width` unchanged.
- Hysteresis: 3500 ×20, 2000 ×50, 1000 -> a single pulse, `pulse_width` = 70. A run of 2000 alone from IDLE never starts a pulse.
- Timeout: 6000 held ×500 -> `pulse_err` at the 400th sample (+1 clk), `sigout` = 0, `pulse_width` = 400. No new pulse until a sample < 1500, after which a 6000 run is accepted normally.
- Gapped valid: 30 samples of 6000 with `sample_valid` high every other cycle, then -100 -> `pulse_width` = 30. Negative sample terminates the pulse.
- Reset mid-pulse: assert `rst_n` low while ACTIVE -> all outputs 0 immediately (asynchronous). After release, an input held at 6000 needs a full `MIN_W` samples again before `sigout` rises.
